// File: rtl/single_pulse_rx.sv
// rtl/single_pulse_rx.sv - classifies key presses into click, double click and long press strobes
module single_pulse_rx #(
  parameter int LONG_CYC = 50000000,
  parameter int DBL_CYC  = 12500000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse,
  input  logic       key1,
  output logic       click,
  output logic       dbl_click,
  output logic       long_press,
  output logic       busy,
  output logic [7:0] evt_cnt
);

  // Timer values seen on the last cycle of each window (timer is cleared on entry).
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD1,
    S_GAP,
    S_HOLD2,
    S_WAIT_REL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             click_q, click_d;
  logic             dbl_q, dbl_d;
  logic             long_q, long_d;
  logic             busy_q;
  logic [7:0]       evt_cnt_q, evt_cnt_d;

  // Next-state, timer and strobe decode; timer saturates instead of wrapping.
  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
    click_d   = 1'b0;
    dbl_d     = 1'b0;
    long_d    = 1'b0;
    evt_cnt_d = evt_cnt_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (pulse) begin
          state_d = S_HOLD1;
        end
      end
      S_HOLD1: begin
        // The hold window expiring wins over a release on the same cycle.
        if (timer_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = S_WAIT_REL;
        end else if (key1) begin
          state_d = S_GAP;
          timer_d = '0;
        end
      end
      S_GAP: begin
        // A pulse landing on the timeout cycle still yields a click and starts a new press.
        if (timer_q == DBL_LAST) begin
          click_d = 1'b1;
          if (pulse) begin
            state_d = S_HOLD1;
            timer_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (pulse) begin
          state_d = S_HOLD2;
          timer_d = '0;
        end
      end
      S_HOLD2: begin
        // Double click is reported on the first cycle after the second pulse.
        if (timer_q == '0) begin
          dbl_d = 1'b1;
        end
        if (key1) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_REL: begin
        if (key1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    if (click_d || dbl_d || long_d) begin
      evt_cnt_d = evt_cnt_q + 8'd1;
    end
  end

  // State, timer and registered outputs; busy lags the state register by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      click_q   <= 1'b0;
      dbl_q     <= 1'b0;
      long_q    <= 1'b0;
      busy_q    <= 1'b0;
      evt_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      click_q   <= click_d;
      dbl_q     <= dbl_d;
      long_q    <= long_d;
      busy_q    <= (state_q != S_IDLE);
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign click      = click_q;
  assign dbl_click  = dbl_q;
  assign long_press = long_q;
  assign busy       = busy_q;
  assign evt_cnt    = evt_cnt_q;

endmodule

// File: tb/tb_single_pulse_rx.sv
// tb/tb_single_pulse_rx.sv - scoreboard bench for single_pulse_rx
module tb_single_pulse_rx;

  localparam int LONG_CYC = 20;
  localparam int DBL_CYC  = 10;

  localparam int K_CLICK = 1;
  localparam int K_DBL   = 2;
  localparam int K_LONG  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pulse = 1'b0;
  logic       key1 = 1'b1;
  logic       click;
  logic       dbl_click;
  logic       long_press;
  logic       busy;
  logic [7:0] evt_cnt;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_evt = 0;

  single_pulse_rx #(
    .LONG_CYC(LONG_CYC),
    .DBL_CYC (DBL_CYC),
    .CNT_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pulse     (pulse),
    .key1      (key1),
    .click     (click),
    .dbl_click (dbl_click),
    .long_press(long_press),
    .busy      (busy),
    .evt_cnt   (evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // One clock edge, then sample outputs and match any strobe against the scoreboard.
  task automatic tick();
    int   strobes;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    strobes = int'({long_press, dbl_click, click});
    if (strobes != 0) begin
      check("onehot", $countones(strobes), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_evt", strobes, 0);
      end else begin
        e = exp_q.pop_front();
        check("evt_kind", strobes, e.kind);
        check("evt_cyc", cyc, e.cyc);
        exp_evt = (exp_evt + 1) % 256;
        check("evt_cnt", int'(evt_cnt), exp_evt);
      end
    end
  endtask

  // Cycles are relative to the call; key1 is low over [p1,r1) and [p2,r2); p2=0 means no second press.
  task automatic run_scn(input int p1, input int r1, input int p2, input int r2,
                         input int len, input int busy_fall);
    for (int rel = 1; rel <= len; rel++) begin
      pulse = (rel == p1) || (p2 > 0 && rel == p2);
      key1  = !((rel >= p1 && rel < r1) || (p2 > 0 && rel >= p2 && rel < r2));
      tick();
      if (busy_fall > 0 && rel == busy_fall - 1) check("busy_before_fall", int'(busy), 1);
      if (busy_fall > 0 && rel == busy_fall) check("busy_fall", int'(busy), 0);
    end
    pulse = 1'b0;
    key1  = 1'b1;
    check("missing_evt", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_click", int'(click), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_evt_cnt", int'(evt_cnt), 0);
    rst = 1'b1;
    tick();

    // single click
    push(K_CLICK, cyc + 115);
    run_scn(100, 105, 0, 0, 130, 116);

    // double click
    push(K_DBL, cyc + 109);
    run_scn(100, 103, 108, 112, 125, 113);

    // long press
    push(K_LONG, cyc + 120);
    run_scn(100, 150, 0, 0, 160, 151);

    // release one cycle before the long-press threshold
    push(K_CLICK, cyc + 129);
    run_scn(100, 119, 0, 0, 140, 130);

    // second pulse exactly at the gap timeout
    push(K_CLICK, cyc + 113);
    push(K_CLICK, cyc + 126);
    run_scn(100, 103, 113, 116, 140, 127);

    // reset while in the gap window
    run_scn(100, 103, 0, 0, 105, 0);
    rst = 1'b0;
    #1;
    exp_evt = 0;
    check("mid_rst_click", int'(click), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_evt_cnt", int'(evt_cnt), 0);
    tick();
    tick();
    rst = 1'b1;
    run_scn(0, 0, 0, 0, 30, 0);
    check("post_rst_evt_cnt", int'(evt_cnt), 0);
    check("post_rst_busy", int'(busy), 0);

    // 256 single clicks wrap the event counter
    for (int i = 0; i < 256; i++) begin
      push(K_CLICK, cyc + 13);
      run_scn(2, 3, 0, 0, 16, 14);
    end
    check("wrap_evt_cnt", int'(evt_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
